// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath: default widths, the quantiser
// shift, and helpers that give the signed saturation bounds for an N-bit sample.
package fir_pkg;

  localparam int N_DEF     = 16;  // sample width; accumulator is 2N
  localparam int COEF_W    = 8;   // signed Q1.7 coefficients
  localparam int SHIFT_DEF = 7;   // fractional bits removed by the output stage
  localparam int DEPTH_DEF = 4;   // output FIFO entries

  // Largest representable N-bit signed value: 2^(N-1)-1.
  function automatic longint sat_max_f(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  // Smallest representable N-bit signed value: -2^(N-1).
  function automatic longint sat_min_f(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Small synchronous FIFO with a registered head word. The head register is
// reloaded on every pop/first-push so the output never glitches while the
// consumer stalls.
module fir_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt_s;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          do_wr_s, do_rd_s;

  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == {(AW + 1){1'b0}});
  assign do_wr_s      = wr_en & ~full;
  assign do_rd_s      = rd_en & ~empty;
  assign rd_ptr_nxt_s = rd_ptr_q + PTR_ONE;
  assign rd_data      = head_q;

  // Next-state for pointers, occupancy and the registered head word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_wr_s, do_rd_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    // Head follows the oldest live entry; a write into an empty (or
    // just-emptied) queue becomes the head directly.
    if (do_rd_s) begin
      if (cnt_q > CNT_ONE) begin
        head_d = mem_q[rd_ptr_nxt_s];
      end else if (do_wr_s) begin
        head_d = wr_data;
      end else begin
        head_d = head_q;
      end
    end else if (do_wr_s && empty) begin
      head_d = wr_data;
    end else begin
      head_d = head_q;
    end
  end

  // State registers; reset discards all queued data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {(AW + 1){1'b0}};
      head_q   <= {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      if (do_wr_s) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/fir_output_stage.sv
// Tail of the FIR tap chain: rounds/shifts/saturates the 2N-bit sum to an
// N-bit sample, queues it behind valid/ready, and enables the tap chain only
// when the result has somewhere to go. Counts saturated samples.
module fir_output_stage
  import fir_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  tap_ena,
  input  logic signed [2*N-1:0] y_acc,
  output logic signed [N-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  clr_stats,
  output logic                  sat_flag,
  output logic [7:0]            sat_count
);

  // One guard bit above the accumulator so adding the rounding constant
  // can never wrap.
  localparam int                    QW      = 2 * N + 1;
  localparam logic        [QW-1:0]  Q_ONE   = {{(QW - 1){1'b0}}, 1'b1};
  localparam logic signed [QW-1:0]  RND     = (Q_ONE << SHIFT) >> 1;  // 0 when SHIFT=0
  localparam logic signed [QW-1:0]  SAT_MAX = QW'(sat_max_f(N));
  localparam logic signed [QW-1:0]  SAT_MIN = QW'(sat_min_f(N));

  logic signed [QW-1:0] acc_ext_s, rnd_sum_s, q_s;
  logic [N-1:0]         q_sat_s;
  logic                 sat_s;
  logic                 sat_push_s;
  logic                 full_s, empty_s;
  logic [N-1:0]         head_s;
  logic                 sat_flag_q, sat_flag_d;
  logic [7:0]           sat_cnt_q, sat_cnt_d;

  assign acc_ext_s = {y_acc[2*N-1], y_acc};
  assign rnd_sum_s = acc_ext_s + RND;
  assign q_s       = rnd_sum_s >>> SHIFT;

  // Clamp the rounded value into the N-bit signed range and flag clipping.
  always_comb begin
    q_sat_s = q_s[N-1:0];
    sat_s   = 1'b0;
    if (q_s > SAT_MAX) begin
      q_sat_s = SAT_MAX[N-1:0];
      sat_s   = 1'b1;
    end else if (q_s < SAT_MIN) begin
      q_sat_s = SAT_MIN[N-1:0];
      sat_s   = 1'b1;
    end else begin
      q_sat_s = q_s[N-1:0];
      sat_s   = 1'b0;
    end
  end

  // Ready depends only on FIFO occupancy, never on m_ready.
  assign s_ready    = ~full_s;
  assign tap_ena    = s_valid & s_ready;
  assign m_valid    = ~empty_s;
  assign m_data     = head_s;
  assign sat_push_s = tap_ena & sat_s;

  fir_sync_fifo #(
    .W     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tap_ena),
    .wr_data (q_sat_s),
    .rd_en   (m_ready),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Saturation statistics; a saturated push in the clear cycle wins.
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_push_s) begin
      sat_flag_d = 1'b1;
      if (clr_stats) begin
        sat_cnt_d = 8'd1;
      end else if (sat_cnt_q == 8'd255) begin
        sat_cnt_d = sat_cnt_q;
      end else begin
        sat_cnt_d = sat_cnt_q + 8'd1;
      end
    end else if (clr_stats) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = 8'd0;
    end else begin
      sat_flag_d = sat_flag_q;
      sat_cnt_d  = sat_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= 8'd0;
    end else begin
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_fir_output_stage.sv
// Self-checking bench for fir_output_stage (N=16, SHIFT=7, DEPTH=4):
// table-driven quantiser vectors plus hand-written multi-cycle sequences,
// with a queue scoreboard and a stats model checked every cycle.
module tb_fir_output_stage;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic               tap_ena;
  logic signed [31:0] y_acc;
  logic signed [15:0] m_data;
  logic               m_valid;
  logic               m_ready;
  logic               clr_stats;
  logic               sat_flag;
  logic [7:0]         sat_count;

  always #5 clk = ~clk;

  fir_output_stage #(
    .N     (16),
    .SHIFT (7),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .tap_ena   (tap_ena),
    .y_acc     (y_acc),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .clr_stats (clr_stats),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  typedef struct {
    logic signed [31:0] y;
    logic signed [15:0] q;
    bit                 sat;
  } vec_t;

  vec_t               tbl [8];
  int                 n_vec = 0;
  int                 n_err = 0;
  int                 tap_cnt = 0;
  logic signed [15:0] mq [$];
  bit                 sflag_m = 1'b0;
  int                 scnt_m = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference quantiser: round half up, shift by 7, clamp to 16 bits.
  function automatic logic signed [15:0] qmodel(input longint y, output bit sat);
    longint q;
    q = (y + 64) >>> 7;
    if (q > 32767) begin
      sat = 1'b1;
      q   = 32767;
    end else if (q < -32768) begin
      sat = 1'b1;
      q   = -32768;
    end else begin
      sat = 1'b0;
    end
    return 16'(q);
  endfunction

  // One clock: check outputs at the falling edge, then update the model at the rising edge.
  task automatic cycle_q(input logic signed [15:0] push_val, input bit push_sat);
    bit exp_push, exp_pop;
    @(negedge clk);
    exp_push = s_valid && (mq.size() < 4);
    exp_pop  = m_ready && (mq.size() > 0);
    check("m_valid", longint'(m_valid), longint'(mq.size() != 0));
    check("s_ready", longint'(s_ready), longint'(mq.size() < 4));
    check("tap_ena", longint'(tap_ena), longint'(exp_push));
    check("sat_flag", longint'(sat_flag), longint'(sflag_m));
    check("sat_count", longint'(sat_count), longint'(scnt_m));
    if (mq.size() != 0) check("m_data", longint'(m_data), longint'(mq[0]));
    if (tap_ena) tap_cnt++;
    @(posedge clk);
    if (exp_pop) void'(mq.pop_front());
    if (exp_push) mq.push_back(push_val);
    if (exp_push && push_sat) begin
      sflag_m = 1'b1;
      scnt_m  = clr_stats ? 1 : ((scnt_m < 255) ? scnt_m + 1 : 255);
    end else if (clr_stats) begin
      sflag_m = 1'b0;
      scnt_m  = 0;
    end
    #1;
  endtask

  task automatic cycle();
    bit                 s;
    logic signed [15:0] v;
    v = qmodel(longint'(y_acc), s);
    cycle_q(v, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{32'sd320,        16'sd3,       1'b0};
    tbl[1] = '{32'sd64,         16'sd1,       1'b0};
    tbl[2] = '{32'sd63,         16'sd0,       1'b0};
    tbl[3] = '{-32'sd320,       -16'sd2,      1'b0};
    tbl[4] = '{-32'sd64,        16'sd0,       1'b0};
    tbl[5] = '{-32'sd65,        -16'sd1,      1'b0};
    tbl[6] = '{32'sh0100_0000,  16'sh7FFF,    1'b1};
    tbl[7] = '{32'sh8000_0000,  16'sh8000,    1'b1};

    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; clr_stats = 1'b0; y_acc = 32'sd0;
    #2;
    check("rst_m_valid", longint'(m_valid), 0);
    check("rst_m_data", longint'(m_data), 0);
    check("rst_s_ready", longint'(s_ready), 1);
    check("rst_tap_ena", longint'(tap_ena), 0);
    check("rst_sat_flag", longint'(sat_flag), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Quantiser table: one push per vector, consumer always ready.
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      y_acc   = tbl[i].y;
      cycle_q(tbl[i].q, tbl[i].sat);
    end
    s_valid = 1'b0;
    cycle();
    cycle();
    check("table_sat_count", longint'(sat_count), 2);
    check("table_sat_flag", longint'(sat_flag), 1);

    // Clear coinciding with a saturated push.
    s_valid = 1'b1; clr_stats = 1'b1; y_acc = 32'sh0100_0000;
    cycle();
    s_valid = 1'b0; clr_stats = 1'b0;
    cycle();
    check("clr_sat_count", longint'(sat_count), 1);
    check("clr_sat_flag", longint'(sat_flag), 1);

    // Backpressure: six offered samples, only four accepted.
    m_ready = 1'b0;
    tap_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1;
      y_acc   = 32'(128 * i);
      cycle();
    end
    s_valid = 1'b0;
    check("bp_tap_pulses", longint'(tap_cnt), 4);
    check("bp_s_ready_full", longint'(s_ready), 0);
    m_ready = 1'b1;
    repeat (6) cycle();

    // Simultaneous push/pop at occupancy two.
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      y_acc   = 32'(1000 * (i + 1));
      cycle();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      y_acc   = $urandom();
      cycle();
    end
    s_valid = 1'b0;
    repeat (3) cycle();

    // Saturation counter holds at 255.
    clr_stats = 1'b1;
    cycle();
    clr_stats = 1'b0;
    s_valid   = 1'b1;
    y_acc     = 32'sh7FFF_FFFF;
    repeat (260) cycle();
    s_valid = 1'b0;
    cycle();
    check("sat_count_hold", longint'(sat_count), 255);

    // Reset with three entries queued.
    m_ready = 1'b0;
    s_valid = 1'b1;
    y_acc = 32'sh0100_0000; cycle();
    y_acc = 32'sd640;       cycle();
    y_acc = -32'sd640;      cycle();
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", longint'(m_valid), 0);
    check("mid_rst_s_ready", longint'(s_ready), 1);
    check("mid_rst_sat_count", longint'(sat_count), 0);
    check("mid_rst_sat_flag", longint'(sat_flag), 0);
    check("mid_rst_tap_ena", longint'(tap_ena), 1);
    mq.delete();
    sflag_m = 1'b0;
    scnt_m  = 0;
    s_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b1; y_acc = 32'sd640;
    cycle();
    s_valid = 1'b0;
    #1;
    check("post_rst_m_valid", longint'(m_valid), 1);
    check("post_rst_m_data", longint'(m_data), 5);
    m_ready = 1'b1;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
